// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Sequencer states, requester port ids and default bus widths.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    localparam int unsigned DEF_ADDR_W = 7;
    localparam int unsigned DEF_DATA_W = 8;

    // Wide enough for the largest supported memory latency (7).
    localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes for both ports plus the shared data-memory bus.
// slave = arbiter side, master = requesters and memory side.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = dmem_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = dmem_pkg::DEF_DATA_W
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              done0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              done1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_dout,
        output gnt0, done0, rdata0,
        output gnt1, done1, rdata1,
        output mem_addr, mem_din, mem_read, mem_write, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_dout,
        input  gnt0, done0, rdata0,
        input  gnt1, done1, rdata1,
        input  mem_addr, mem_din, mem_read, mem_write, busy
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way winner selection; the pointer register lives in the parent.
// A lone requester always wins; a tie goes to ptr_i, or port 0 when fixed_i is set.
module rr_pick2
    import dmem_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic ptr_i,
    input  logic fixed_i,
    output logic winner_o,
    output logic valid_o
);

    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = PORT_CORE;
        if (req0_i && req1_i) begin
            winner_o = fixed_i ? PORT_CORE : ptr_i;
        end else if (req1_i) begin
            winner_o = PORT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer owning all strobes of the 128x8 data memory.
// One transaction at a time: IDLE grants, ISSUE strobes for one cycle, WAIT covers memory latency.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    state_e             state_q, state_d;
    logic               win_q, win_d;
    logic               we_q, we_d;
    logic               ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic               done0_q, done0_d, done1_q, done1_d;
    logic               mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_din_q, mem_din_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic               busy_q, busy_d;

    logic pick_win, pick_valid, sel_we;

    rr_pick2 u_pick (
        .req0_i   (bus.req0),
        .req1_i   (bus.req1),
        .ptr_i    (ptr_q),
        .fixed_i  (FIXED_PRI != 0),
        .winner_o (pick_win),
        .valid_o  (pick_valid)
    );

    assign sel_we = (pick_win == PORT_DBG) ? bus.we1 : bus.we0;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d       = pick_win;
                    we_d        = sel_we;
                    gnt0_d      = (pick_win == PORT_CORE);
                    gnt1_d      = (pick_win == PORT_DBG);
                    mem_addr_d  = (pick_win == PORT_DBG) ? bus.addr1 : bus.addr0;
                    mem_din_d   = (pick_win == PORT_DBG) ? bus.wdata1 : bus.wdata0;
                    mem_read_d  = !sel_we;
                    mem_write_d = sel_we;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                // The counter value 1 marks the edge where mem_dout is valid.
                if (cnt_q == CNT_W'(1)) begin
                    if (!we_q) begin
                        if (win_q == PORT_DBG) rdata1_d = bus.mem_dout;
                        else                   rdata0_d = bus.mem_dout;
                    end
                    done0_d = (win_q == PORT_CORE);
                    done1_d = (win_q == PORT_DBG);
                    if (FIXED_PRI == 0) ptr_d = ~win_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_q       <= PORT_CORE;
            we_q        <= 1'b0;
            ptr_q       <= PORT_CORE;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin/MEM_LAT=1, fixed-priority and MEM_LAT=4 instances,
// each with its own 128x8 memory model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    dmem_arbiter_if #(.ADDR_W(7), .DATA_W(8)) b0 ();
    dmem_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bf ();
    dmem_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bl ();

    dmem_arbiter #(.ADDR_W(7), .DATA_W(8), .MEM_LAT(1), .FIXED_PRI(0)) u_rr (.clk(clk), .rst(rst), .bus(b0));
    dmem_arbiter #(.ADDR_W(7), .DATA_W(8), .MEM_LAT(1), .FIXED_PRI(1)) u_fx (.clk(clk), .rst(rst), .bus(bf));
    dmem_arbiter #(.ADDR_W(7), .DATA_W(8), .MEM_LAT(4), .FIXED_PRI(0)) u_l4 (.clk(clk), .rst(rst), .bus(bl));

    logic [7:0] mem0 [128];
    logic [7:0] memf [128];
    logic [7:0] meml [128];
    logic       pl_en = 1'b0;
    logic [1:0] pl_sel = 2'd0;
    logic [6:0] pl_addr = 7'd0;
    logic [7:0] pl_data = 8'd0;

    always @(posedge clk) begin
        if (pl_en && pl_sel == 2'd0) mem0[pl_addr] <= pl_data;
        else if (b0.mem_write)       mem0[b0.mem_addr] <= b0.mem_din;
        if (pl_en && pl_sel == 2'd1) memf[pl_addr] <= pl_data;
        else if (bf.mem_write)       memf[bf.mem_addr] <= bf.mem_din;
        if (pl_en && pl_sel == 2'd2) meml[pl_addr] <= pl_data;
        else if (bl.mem_write)       meml[bl.mem_addr] <= bl.mem_din;
    end

    assign b0.mem_dout = mem0[b0.mem_addr];
    assign bf.mem_dout = memf[bf.mem_addr];
    assign bl.mem_dout = meml[bl.mem_addr];

    initial begin
        b0.req0 = 0; b0.we0 = 0; b0.addr0 = '0; b0.wdata0 = '0;
        b0.req1 = 0; b0.we1 = 0; b0.addr1 = '0; b0.wdata1 = '0;
        bf.req0 = 0; bf.we0 = 0; bf.addr0 = '0; bf.wdata0 = '0;
        bf.req1 = 0; bf.we1 = 0; bf.addr1 = '0; bf.wdata1 = '0;
        bl.req0 = 0; bl.we0 = 0; bl.addr0 = '0; bl.wdata0 = '0;
        bl.req1 = 0; bl.we1 = 0; bl.addr1 = '0; bl.wdata1 = '0;
    end

    task automatic preload(input logic [1:0] sel, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_sel = sel; pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Leaves the caller on the negedge right after reset drops.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({b0.busy, b0.gnt0, b0.gnt1, b0.done0, b0.done1, b0.mem_read, b0.mem_write,
             b0.mem_addr, b0.mem_din, b0.rdata0, b0.rdata1} !== '0) begin
            bad++; $display("FAIL reset_rr got busy=%b mem_addr=%h rdata0=%h rdata1=%h want all zero",
                            b0.busy, b0.mem_addr, b0.rdata0, b0.rdata1);
        end
        total++;
        if ({bf.busy, bf.gnt0, bf.gnt1, bf.done0, bf.done1, bf.mem_read, bf.mem_write,
             bf.mem_addr, bf.mem_din, bf.rdata0, bf.rdata1} !== '0) begin
            bad++; $display("FAIL reset_fx got busy=%b mem_addr=%h want all zero", bf.busy, bf.mem_addr);
        end
        total++;
        if ({bl.busy, bl.gnt0, bl.gnt1, bl.done0, bl.done1, bl.mem_read, bl.mem_write,
             bl.mem_addr, bl.mem_din, bl.rdata0, bl.rdata1} !== '0) begin
            bad++; $display("FAIL reset_l4 got busy=%b mem_addr=%h want all zero", bl.busy, bl.mem_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        preload(2'd0, 7'h05, 8'hA7);
        do_reset();
        b0.req1 = 1; b0.we1 = 0; b0.addr1 = 7'h05;
        @(negedge clk);
        total++;
        if ({b0.gnt0, b0.gnt1, b0.mem_read, b0.mem_write, b0.busy} !== 5'b01101 || b0.mem_addr !== 7'h05) begin
            bad++; $display("FAIL sr_grant got g0g1rwb=%b addr=%h want 01101 addr=05",
                            {b0.gnt0, b0.gnt1, b0.mem_read, b0.mem_write, b0.busy}, b0.mem_addr);
        end
        b0.req1 = 0;
        @(negedge clk);
        total++;
        if ({b0.gnt1, b0.mem_read, b0.mem_write, b0.done1, b0.busy} !== 5'b00001) begin
            bad++; $display("FAIL sr_wait got g1rwdb=%b want 00001",
                            {b0.gnt1, b0.mem_read, b0.mem_write, b0.done1, b0.busy});
        end
        @(negedge clk);
        total++;
        if ({b0.done0, b0.done1, b0.mem_write, b0.busy} !== 4'b0100 || b0.rdata1 !== 8'hA7) begin
            bad++; $display("FAIL sr_done got d0d1wb=%b rdata1=%h want 0100 rdata1=a7",
                            {b0.done0, b0.done1, b0.mem_write, b0.busy}, b0.rdata1);
        end
        @(negedge clk);
        total++;
        if (b0.done1 !== 1'b0 || b0.rdata1 !== 8'hA7) begin
            bad++; $display("FAIL sr_after got done1=%b rdata1=%h want 0 a7", b0.done1, b0.rdata1);
        end
    endtask

    task automatic test_write_read();
        preload(2'd0, 7'h7F, 8'h00);
        do_reset();
        b0.req0 = 1; b0.we0 = 1; b0.addr0 = 7'h7F; b0.wdata0 = 8'h3C;
        @(negedge clk);
        total++;
        if ({b0.gnt0, b0.gnt1, b0.mem_read, b0.mem_write, b0.busy} !== 5'b10011
            || b0.mem_addr !== 7'h7F || b0.mem_din !== 8'h3C) begin
            bad++; $display("FAIL wr_strobe got g0g1rwb=%b addr=%h din=%h want 10011 7f 3c",
                            {b0.gnt0, b0.gnt1, b0.mem_read, b0.mem_write, b0.busy}, b0.mem_addr, b0.mem_din);
        end
        b0.req0 = 0;
        @(negedge clk);
        total++;
        if ({b0.mem_read, b0.mem_write, b0.done0} !== 3'b000 || b0.mem_din !== 8'h3C) begin
            bad++; $display("FAIL wr_wait got rwd=%b din=%h want 000 3c",
                            {b0.mem_read, b0.mem_write, b0.done0}, b0.mem_din);
        end
        @(negedge clk);
        total++;
        if (b0.done0 !== 1'b1 || mem0[7'h7F] !== 8'h3C) begin
            bad++; $display("FAIL wr_done got done0=%b mem[7f]=%h want 1 3c", b0.done0, mem0[7'h7F]);
        end
        b0.req0 = 1; b0.we0 = 0; b0.addr0 = 7'h7F;
        @(negedge clk);
        total++;
        if ({b0.gnt0, b0.gnt1, b0.mem_read, b0.mem_write, b0.busy} !== 5'b10101 || b0.mem_addr !== 7'h7F) begin
            bad++; $display("FAIL rd_grant got g0g1rwb=%b addr=%h want 10101 7f",
                            {b0.gnt0, b0.gnt1, b0.mem_read, b0.mem_write, b0.busy}, b0.mem_addr);
        end
        b0.req0 = 0;
        repeat (2) @(negedge clk);
        total++;
        if (b0.done0 !== 1'b1 || b0.rdata0 !== 8'h3C) begin
            bad++; $display("FAIL rd_done got done0=%b rdata0=%h want 1 3c", b0.done0, b0.rdata0);
        end
    endtask

    task automatic test_round_robin();
        int ng = 0;
        int last_cyc = 0;
        logic outst = 1'b0;
        logic last_port = 1'b0;
        logic port;
        preload(2'd0, 7'h01, 8'h11);
        preload(2'd0, 7'h02, 8'h22);
        do_reset();
        b0.req0 = 1; b0.we0 = 0; b0.addr0 = 7'h01;
        b0.req1 = 1; b0.we1 = 0; b0.addr1 = 7'h02;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            total++;
            if ((b0.mem_read && b0.mem_write) || (b0.gnt0 && b0.gnt1) || (b0.done0 && b0.done1)) begin
                bad++; $display("FAIL rr_excl cyc=%0d got r=%b w=%b g=%b%b d=%b%b want no overlap",
                                cyc, b0.mem_read, b0.mem_write, b0.gnt0, b0.gnt1, b0.done0, b0.done1);
            end
            if (b0.done0 || b0.done1) begin
                total++;
                if (!outst || b0.done1 !== last_port
                    || (last_port ? b0.rdata1 : b0.rdata0) !== (last_port ? 8'h22 : 8'h11)) begin
                    bad++; $display("FAIL rr_done cyc=%0d got done1=%b r0=%h r1=%h want port %0d data %h",
                                    cyc, b0.done1, b0.rdata0, b0.rdata1, last_port, last_port ? 8'h22 : 8'h11);
                end
                outst = 1'b0;
            end
            if (b0.gnt0 || b0.gnt1) begin
                port = b0.gnt1;
                total++;
                if (port !== ng[0] || outst || (ng > 0 && cyc - last_cyc != 3)) begin
                    bad++; $display("FAIL rr_order grant#%0d got port=%0d gap=%0d outst=%b want port=%0d gap=3 outst=0",
                                    ng, port, cyc - last_cyc, outst, ng[0]);
                end
                outst = 1'b1; last_port = port; last_cyc = cyc; ng++;
                if (ng == 4) begin
                    b0.req0 = 0; b0.req1 = 0;
                end
            end
            if (ng == 4 && !outst) break;
        end
        total++;
        if (ng != 4 || outst) begin
            bad++; $display("FAIL rr_timeout got grants=%0d outstanding=%b want 4 0", ng, outst);
        end
    endtask

    task automatic test_fixed_pri();
        int g0 = 0;
        int c3 = 0;
        logic got1 = 1'b0;
        preload(2'd1, 7'h01, 8'h11);
        do_reset();
        bf.req0 = 1; bf.we0 = 0; bf.addr0 = 7'h01;
        bf.req1 = 1; bf.we1 = 0; bf.addr1 = 7'h02;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bf.gnt0) begin
                g0++;
                if (g0 == 3) begin
                    c3 = cyc;
                    bf.req0 = 0;
                end
            end
            if (bf.gnt1) begin
                total++;
                if (g0 != 3 || cyc - c3 != 3) begin
                    bad++; $display("FAIL fx_gnt1 got after %0d port0 grants gap=%0d want 3 gap=3", g0, cyc - c3);
                end
                got1 = 1'b1;
                bf.req1 = 0;
                break;
            end
        end
        total++;
        if (!got1 || g0 != 3) begin
            bad++; $display("FAIL fx_count got port0 grants=%0d gnt1_seen=%b want 3 1", g0, got1);
        end
        total++;
        if (bf.rdata0 !== 8'h11) begin
            bad++; $display("FAIL fx_rdata0 got %h want 11", bf.rdata0);
        end
    endtask

    task automatic test_mem_lat4();
        preload(2'd2, 7'h10, 8'h55);
        do_reset();
        bl.req0 = 1; bl.we0 = 0; bl.addr0 = 7'h10;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) bl.req0 = 0;
            total++;
            if ({bl.mem_read, bl.done0, bl.busy} !== {k == 1, k == 6, k < 6} || bl.mem_addr !== 7'h10) begin
                bad++; $display("FAIL l4_seq k=%0d got rdb=%b addr=%h want %b%b%b addr=10",
                                k, {bl.mem_read, bl.done0, bl.busy}, bl.mem_addr, k == 1, k == 6, k < 6);
            end
        end
        total++;
        if (bl.rdata0 !== 8'h55) begin
            bad++; $display("FAIL l4_rdata0 got %h want 55", bl.rdata0);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_done = 1'b0;
        do_reset();
        bl.req1 = 1; bl.we1 = 0; bl.addr1 = 7'h10;
        @(negedge clk);
        total++;
        if (bl.gnt1 !== 1'b1) begin
            bad++; $display("FAIL rm_gnt1 got %b want 1", bl.gnt1);
        end
        bl.req1 = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bl.busy, bl.done1, bl.mem_read, bl.gnt1} !== 4'b0000 || bl.rdata1 !== 8'h00) begin
            bad++; $display("FAIL rm_reset got bdrg=%b rdata1=%h want 0000 00",
                            {bl.busy, bl.done1, bl.mem_read, bl.gnt1}, bl.rdata1);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bl.done1 || bl.busy) saw_done = 1'b1;
        end
        total++;
        if (saw_done) begin
            bad++; $display("FAIL rm_quiet got done1/busy activity after reset want none");
        end
        bl.req0 = 1; bl.we0 = 0; bl.addr0 = 7'h10;
        bl.req1 = 1; bl.we1 = 0; bl.addr1 = 7'h10;
        @(negedge clk);
        total++;
        if ({bl.gnt0, bl.gnt1} !== 2'b10) begin
            bad++; $display("FAIL rm_regrant got g0g1=%b want 10", {bl.gnt0, bl.gnt1});
        end
        bl.req0 = 0; bl.req1 = 0;
        repeat (5) @(negedge clk);
        total++;
        if (bl.done0 !== 1'b1 || bl.rdata0 !== 8'h55 || bl.rdata1 !== 8'h00) begin
            bad++; $display("FAIL rm_done got done0=%b rdata0=%h rdata1=%h want 1 55 00",
                            bl.done0, bl.rdata0, bl.rdata1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_round_robin();
        test_fixed_pri();
        test_mem_lat4();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the 128x8 data memory.
- Shares the single memRead/memWrite/lineNumber/memIn port between the processor core (port 0) and the debug/loader port (port 1).
- Owns all memory strobes, so requesters never drive the memory directly.
- Round-robin by default; each accepted transaction runs to completion before the next grant.

Parameters:
- ADDR_W, 7, data-memory address width (128 lines).
- DATA_W, 8, data-memory word width.
- MEM_LAT, 1, cycles from strobe deassert until mem_dout is valid (1..7).
- FIXED_PRI, 0, 0 = round-robin; 1 = port 0 always wins a tie.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; hold until gnt0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  ADDR_W  port 0 line number.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  one-cycle pulse: port 0 request accepted.
- done0  out  1  one-cycle pulse: port 0 transaction complete.
- rdata0  out  DATA_W  port 0 read data; valid when done0, held until next port 0 read completes.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1: same as port 0, for port 1.
- mem_addr  out  ADDR_W  to dataMemory lineNumber.
- mem_din  out  DATA_W  to dataMemory memIn.
- mem_read  out  1  to dataMemory memRead.
- mem_write  out  1  to dataMemory memWrite.
- mem_dout  in  DATA_W  from dataMemory memOut.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE; gnt*, done*, mem_read, mem_write, busy = 0; mem_addr, mem_din, rdata0, rdata1 = 0; priority pointer = port 0; wait counter = 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - No req: stay in IDLE.
  - Any req: choose the winner.
  - One request: that port wins.
  - Both requesting: the pointer port wins (or port 0 if FIXED_PRI=1).
  - Same edge: latch winner id, we, addr, wdata; set gnt<winner>=1; set mem_addr=addr, mem_din=wdata; set mem_read=!we or mem_write=we; go to ISSUE.
- ISSUE (exactly one cycle):
  - Strobe is high during this cycle. gnt is deasserted at the next edge.
  - At that edge: clear the strobe, load counter=MEM_LAT, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - At the edge where the counter reaches 1:
    - If read: rdata<winner> <= mem_dout.
    - Pulse done<winner>=1.
    - Non-fixed mode: pointer flips to the other port.
    - Go to IDLE.
  - mem_addr and mem_din stay stable through WAIT.
- Latency: req sampled high in IDLE at edge E gives gnt and strobe during cycle E..E+1, and done during cycle E+1+MEM_LAT..E+2+MEM_LAT.
- Throughput: one transaction per MEM_LAT+2 cycles. A held req is regranted on the first edge in IDLE.
- Starvation bound: in round-robin mode, a continuously requesting port is granted after at most one transaction of the other port.
- Request rules:
  - Requesters must hold req, we, addr and wdata stable until gnt; they may drop req the cycle after gnt.
  - A req dropped before grant is not served.
  - A req raised during ISSUE or WAIT waits for IDLE.
- Mutual exclusion: mem_read and mem_write are never both high. gnt0 and gnt1 are never both high. done0 and done1 are never both high.
- Reset mid-transaction:
  - At the reset edge: all strobes drop, the FSM returns to IDLE, no done is generated, rdata is cleared.
  - A write whose strobe was already high may have committed; this is acceptable.
- No reordering. Each port has at most one outstanding transaction.

Decomposition:
- Shared package dmem_pkg:
  - state enum (IDLE/ISSUE/WAIT);
  - port-id constants PORT_CORE=0, PORT_DBG=1;
  - default ADDR_W and DATA_W.
- Optional sub-module rr_pick2: combinational 2-way picker (req0, req1, ptr, fixed → winner, valid). Pointer register stays in the parent.

Test Plan:
- Single read: preload line 0x05=0xA7; req1 read addr 0x05 with MEM_LAT=1 → gnt1 one cycle later, mem_read high one cycle, done1 and rdata1=0xA7 three cycles after req, mem_write stays 0.
- Write then read: port 0 writes 0x3C to 0x7F, then reads 0x7F → mem_write for one cycle with mem_addr=0x7F and mem_din=0x3C; later done0 with rdata0=0x3C.
- Simultaneous requests, round-robin: req0 and req1 held continuously, reads of 0x01 and 0x02 → grant order 0,1,0,1, each done before the next gnt, never two strobes at once.
- FIXED_PRI=1: both held for 3 transactions → all 3 grants to port 0; port 1 is granted on the first idle after req0 drops.
- MEM_LAT=4: read of 0x10=0x55 → done at req+6 cycles; mem_addr stable through WAIT; rdata=0x55.
- Reset during WAIT of a port 1 read → no done1; rdata1=0; busy=0; next req0 is granted normally from IDLE with pointer = port 0.
